// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M/RV64M shift-add multiplier and restoring divider on one datapath.
// Define MULDIV_FAST_ZERO_EN to finish zero-operand multiplies and zero-dividend divides straight from PREP.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand1,
    input  logic [XLEN-1:0] operand2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;
    state_t state, state_n;

    logic [2:0]        op_r;
    logic [XLEN-1:0]   a, b, dvs;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;
    logic              neg_q, neg_r;

    logic              is_div, sa, sb, neg_a, neg_b, div_zero, ovf, fast_zero, special;
    logic [XLEN-1:0]   mag_a, mag_b, spec_res, q, r, fix_res;
    logic [XLEN:0]     mul_sum, rem_sh, diff;
    logic [2*XLEN-1:0] mul_next, div_next, prod;

    assign is_div = op_r[2];
    assign sb     = (op_r == 3'b001) | (op_r[2] & ~op_r[0]);
    assign sa     = sb | (op_r == 3'b010);
    assign neg_a  = sa & a[XLEN-1];
    assign neg_b  = sb & b[XLEN-1];
    assign mag_a  = neg_a ? -a : a;
    assign mag_b  = neg_b ? -b : b;

    assign div_zero = is_div & (b == '0);
    assign ovf      = is_div & ~op_r[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
`ifdef MULDIV_FAST_ZERO_EN
    assign fast_zero = is_div ? ((a == '0) & (b != '0)) : ((a == '0) | (b == '0));
`else
    assign fast_zero = 1'b0;
`endif
    assign special  = div_zero | ovf | fast_zero;
    assign spec_res = div_zero ? (op_r[1] ? a : '1) : fast_zero ? '0 : (op_r[1] ? '0 : a);

    // Multiplier sits in the low half of acc and is consumed as the product shifts in from above.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, dvs};
    assign mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
    // Upper half holds the partial remainder; the bit shifted out of it is kept as bit XLEN.
    assign rem_sh   = acc[2*XLEN-1:XLEN-1];
    assign diff     = rem_sh - {1'b0, dvs};
    assign div_next = diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0} : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod    = neg_q ? -acc : acc;
    assign q       = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign r       = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign fix_res = ~is_div ? ((op_r == 3'b000) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                             : (op_r[1] ? r : q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        in_ready = (state == IDLE) | (state == DONE);
        busy     = (state == PREP) | (state == CALC) | (state == FIX);
        done     = state == DONE;
        case (state)
            IDLE, DONE: state_n = in_valid ? PREP : IDLE;
            PREP:       state_n = special ? DONE : CALC;
            CALC:       state_n = (cnt == CNT_W'(1)) ? FIX : CALC;
            FIX:        state_n = DONE;
            default:    state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= '0;
            a      <= '0;
            b      <= '0;
            dvs    <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            result <= '0;
        end else begin
            if (in_valid & in_ready & ~flush) begin
                op_r <= op;
                a    <= operand1;
                b    <= operand2;
            end
            if (state == PREP) begin
                neg_q <= neg_a ^ neg_b;
                neg_r <= neg_a;
                dvs   <= mag_b;
                acc   <= {{XLEN{1'b0}}, mag_a};
                cnt   <= CNT_W'(XLEN);
                if (special & ~flush) result <= spec_res;
            end
            if (state == CALC) begin
                acc <= is_div ? div_next : mul_next;
                cnt <= cnt - 1'b1;
            end
            if ((state == FIX) & ~flush) result <= fix_res;
        end
    end
endmodule
